// File: rtl/haraka_feeder.sv
// Haraka-512 host front end: gathers a 512-bit block from a 64-bit stream, sequences the core,
// and returns a 256-bit truncated digest as four 64-bit words. Optional macro: HARAKA_FEEDFWD_EN.
module haraka_feeder #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [63:0]  s_data,
  input  logic         s_valid,
  output logic         s_ready,
  output logic [63:0]  m_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [511:0] core_in,
  output logic         core_start,
  input  logic [511:0] core_out,
  input  logic         core_done,
  output logic         busy,
  output logic         err
);

  localparam int unsigned WORD_W = 64;
  localparam int unsigned LANES  = 8;
  localparam int unsigned TCNT_W = 8;

  typedef enum logic [1:0] {ST_LOAD, ST_RUN, ST_WAIT, ST_DRAIN} state_e;

  state_e                          state_q, state_d;
  logic [LANES-1:0][WORD_W-1:0]    blk_q, blk_d;
  logic [2:0]                      wcnt_q, wcnt_d;
  logic [1:0]                      dcnt_q, dcnt_d;
  logic [TCNT_W-1:0]               tcnt_q, tcnt_d;
  logic [2:0][WORD_W-1:0]          dig_q, dig_d;
  logic [WORD_W-1:0]               m_data_q, m_data_d;
  logic                            start_q, start_d;
  logic                            err_q, err_d;
  logic [LANES-1:0][WORD_W-1:0]    res_c;
  logic                            unused_res_c;

`ifdef HARAKA_FEEDFWD_EN
  assign res_c = core_out ^ blk_q;
`else
  assign res_c = core_out;
`endif

  // Digest keeps lanes 1,3,4,6 only; the remaining lanes are dropped by truncation.
  assign unused_res_c = ^{res_c[0], res_c[2], res_c[5], res_c[7]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_LOAD;
      blk_q    <= '0;
      wcnt_q   <= '0;
      dcnt_q   <= '0;
      tcnt_q   <= '0;
      dig_q    <= '0;
      m_data_q <= '0;
      start_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      blk_q    <= blk_d;
      wcnt_q   <= wcnt_d;
      dcnt_q   <= dcnt_d;
      tcnt_q   <= tcnt_d;
      dig_q    <= dig_d;
      m_data_q <= m_data_d;
      start_q  <= start_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    blk_d    = blk_q;
    wcnt_d   = wcnt_q;
    dcnt_d   = dcnt_q;
    tcnt_d   = tcnt_q;
    dig_d    = dig_q;
    m_data_d = m_data_q;
    start_d  = 1'b0;
    err_d    = err_q;
    unique case (state_q)
      ST_LOAD: begin
        if (s_valid) begin
          blk_d[wcnt_q] = s_data;
          wcnt_d        = wcnt_q + 3'd1;
          if (wcnt_q == 3'd7) begin
            state_d = ST_RUN;
            start_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        tcnt_d  = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        tcnt_d = tcnt_q + TCNT_W'(1);
        if (core_done) begin
          // First digest word goes straight to the output register so it is valid next cycle.
          m_data_d = res_c[1];
          dig_d    = {res_c[6], res_c[4], res_c[3]};
          dcnt_d   = '0;
          state_d  = ST_DRAIN;
        end else if (tcnt_q == TCNT_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_DRAIN: begin
        if (m_ready) begin
          dcnt_d   = dcnt_q + 2'd1;
          m_data_d = dig_q[0];
          dig_d    = {WORD_W'(0), dig_q[2:1]};
          if (dcnt_q == 2'd3) begin
            state_d = ST_LOAD;
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  assign s_ready    = (state_q == ST_LOAD);
  assign m_valid    = (state_q == ST_DRAIN);
  assign busy       = (state_q != ST_LOAD);
  assign m_data     = m_data_q;
  assign core_in    = blk_q;
  assign core_start = start_q;
  assign err        = err_q;

endmodule

// File: tb/tb_haraka_feeder.sv
// Directed self-checking bench for haraka_feeder with a behavioural Haraka core stand-in.
module tb_haraka_feeder;

  localparam int unsigned TIMEOUT = 16;
  localparam int          LAT     = 10;
  localparam logic [511:0] GARBAGE = {8{64'hDEAD_BEEF_0BAD_F00D}};

  logic         clk;
  logic         rst_n;
  logic [63:0]  s_data;
  logic         s_valid;
  logic         s_ready;
  logic [63:0]  m_data;
  logic         m_valid;
  logic         m_ready;
  logic [511:0] core_in;
  logic         core_start;
  logic [511:0] core_out;
  logic         core_done;
  logic         busy;
  logic         err;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  haraka_feeder #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(rst_n),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .core_in(core_in), .core_start(core_start),
    .core_out(core_out), .core_done(core_done),
    .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Core stand-in: result lane k = input lane k + 0x100, done LAT cycles after start.
  logic         core_en  = 1'b1;
  logic         spur_run = 1'b0;
  int           spur_req = 0;
  int           spur_ack = 0;
  int           done_cyc = -1;
  int           pend     = 0;
  logic [511:0] resp;

  initial begin
    core_done = 1'b0;
    core_out  = GARBAGE;
    resp      = '0;
    forever begin
      @(posedge clk); #1;
      core_done = 1'b0;
      core_out  = GARBAGE;
      if (!rst_n) begin
        pend = 0;
      end else if (pend > 0) begin
        pend = pend - 1;
        if (pend == 0) begin
          core_done = 1'b1;
          core_out  = resp;
          done_cyc  = cyc;
        end
      end else if (core_start && core_en) begin
        pend = LAT;
        for (int k = 0; k < 8; k++) resp[64*k +: 64] = core_in[64*k +: 64] + 64'h100;
        if (spur_run) core_done = 1'b1;
      end else if (spur_req != spur_ack) begin
        spur_ack  = spur_req;
        core_done = 1'b1;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [63:0] rlane(input logic [63:0] b);
    logic [63:0] r;
    r = b + 64'h100;
`ifdef HARAKA_FEEDFWD_EN
    r = r ^ b;
`endif
    return r;
  endfunction

  task automatic exp_digest(input logic [63:0] w [8], output logic [63:0] e [4]);
    e[0] = rlane(w[1]);
    e[1] = rlane(w[3]);
    e[2] = rlane(w[4]);
    e[3] = rlane(w[6]);
  endtask

  task automatic send_block(input logic [63:0] w [8], input bit gaps, input string tag);
    int  i     = 0;
    int  guard = 0;
    bit  acc;
    while (i < 8 && guard < 200) begin
      s_valid = 1'b1;
      s_data  = w[i];
      acc     = s_ready;
      tick();
      guard++;
      if (acc) begin
        i++;
        if (gaps && i < 8) begin
          s_valid = 1'b0;
          tick();
        end
      end
    end
    s_valid = 1'b0;
    s_data  = '0;
    check({tag, " accept_all"}, 64'(i), 64'd8);
    check({tag, " core_start"}, 64'(core_start), 64'd1);
    for (int k = 0; k < 8; k++)
      check($sformatf("%s core_in[%0d]", tag, k), core_in[64*k +: 64], w[k]);
  endtask

  task automatic drain(input logic [63:0] e [4], input int stall_idx, input int stall_n,
                       input string tag);
    int          got    = 0;
    int          stalls = 0;
    int          guard  = 0;
    logic [63:0] held   = '0;
    while (got < 4 && guard < 100) begin
      if (m_valid) begin
        if (got == 0 && stalls == 0)
          check({tag, " first_valid_cyc"}, 64'(cyc), 64'(done_cyc + 1));
        if (got == stall_idx && stalls < stall_n) begin
          m_ready = 1'b0;
          if (stalls > 0) check($sformatf("%s stable%0d", tag, stalls), m_data, held);
          held = m_data;
          stalls++;
        end else begin
          m_ready = 1'b1;
          check($sformatf("%s word%0d", tag, got), m_data, e[got]);
          got++;
        end
      end else begin
        m_ready = 1'b1;
      end
      tick();
      guard++;
    end
    m_ready = 1'b1;
    check({tag, " word_count"}, 64'(got), 64'd4);
    check({tag, " m_valid_after"}, 64'(m_valid), 64'd0);
    check({tag, " s_ready_after"}, 64'(s_ready), 64'd1);
    if (stall_n == 0) check({tag, " s_ready_cyc"}, 64'(cyc), 64'(done_cyc + 5));
  endtask

  task automatic reset_outputs(input string tag);
    check({tag, " s_ready"},    64'(s_ready),    64'd1);
    check({tag, " m_valid"},    64'(m_valid),    64'd0);
    check({tag, " m_data"},     m_data,          64'd0);
    check({tag, " core_start"}, 64'(core_start), 64'd0);
    check({tag, " core_in"},    64'(|core_in),   64'd0);
    check({tag, " busy"},       64'(busy),       64'd0);
  endtask

  initial begin
    logic [63:0] w [8];
    logic [63:0] e [4];
    int          t1;
    int          guard;

    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b1;
    tick(); tick();
    reset_outputs("reset");
    check("reset err", 64'(err), 64'd0);
    rst_n = 1'b1;
    tick();

    // Basic block: lane k = k, core returns 0x100+k.
    for (int k = 0; k < 8; k++) w[k] = 64'(k);
`ifdef HARAKA_FEEDFWD_EN
    e[0] = 64'h100; e[1] = 64'h100; e[2] = 64'h100; e[3] = 64'h100;
`else
    e[0] = 64'h101; e[1] = 64'h103; e[2] = 64'h104; e[3] = 64'h106;
`endif
    send_block(w, 1'b0, "basic");
    tick();
    check("basic busy_wait", 64'(busy), 64'd1);
    check("basic start_one_cycle", 64'(core_start), 64'd0);
    drain(e, -1, 0, "basic");

    // Output back-pressure on the second digest word.
    for (int k = 0; k < 8; k++) w[k] = 64'h1111_0000_0000_0000 * 64'(k + 1) + 64'(k * 3);
    exp_digest(w, e);
    send_block(w, 1'b0, "bp");
    drain(e, 1, 3, "bp");

    // Input gaps every other cycle.
    for (int k = 0; k < 8; k++) w[k] = 64'hA5A5_0000_0000_0000 | 64'(k << 8) | 64'(7 - k);
    exp_digest(w, e);
    send_block(w, 1'b1, "gaps");
    drain(e, -1, 0, "gaps");

    // Spurious done while idle, then in the RUN cycle.
    spur_req++;
    tick(); tick(); tick();
    check("spur_load s_ready", 64'(s_ready), 64'd1);
    check("spur_load m_valid", 64'(m_valid), 64'd0);
    check("spur_load busy",    64'(busy),    64'd0);
    spur_run = 1'b1;
    for (int k = 0; k < 8; k++) w[k] = 64'h0F0F_0F0F_0000_0000 + 64'(k * 17);
    exp_digest(w, e);
    send_block(w, 1'b0, "spur_run");
    drain(e, -1, 0, "spur_run");
    spur_run = 1'b0;

    // Timeout: core never answers.
    core_en = 1'b0;
    for (int k = 0; k < 8; k++) w[k] = 64'h5555_0000 + 64'(k);
    send_block(w, 1'b0, "tmo");
    t1    = cyc;
    guard = 0;
    while (!err && guard < 100) begin
      tick();
      guard++;
    end
    check("tmo err_cyc", 64'(cyc), 64'(t1 + 17));
    check("tmo s_ready", 64'(s_ready), 64'd1);
    check("tmo busy",    64'(busy),    64'd0);
    core_en = 1'b1;
    for (int k = 0; k < 8; k++) w[k] = 64'h7777_0000 + 64'(k * 5);
    exp_digest(w, e);
    send_block(w, 1'b0, "post_tmo");
    drain(e, -1, 0, "post_tmo");
    check("post_tmo err_sticky", 64'(err), 64'd1);

    // Reset after five words of a block.
    for (int k = 0; k < 5; k++) begin
      s_valid = 1'b1;
      s_data  = 64'hBAD0_0000 + 64'(k);
      tick();
    end
    s_valid = 1'b0;
    rst_n   = 1'b0;
    #1;
    reset_outputs("rst_blk");
    check("rst_blk err", 64'(err), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < 8; k++) w[k] = 64'h2000 + 64'(k * 16);
    exp_digest(w, e);
    send_block(w, 1'b0, "rst_blk");
    drain(e, -1, 0, "rst_blk");

    // Reset while the digest is draining.
    for (int k = 0; k < 8; k++) w[k] = 64'h3000 + 64'(k);
    send_block(w, 1'b0, "rst_drn");
    guard = 0;
    while (!m_valid && guard < 50) begin
      tick();
      guard++;
    end
    check("rst_drn m_valid_seen", 64'(m_valid), 64'd1);
    tick();
    check("rst_drn m_valid_mid", 64'(m_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    reset_outputs("rst_drn");
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_drn idle", 64'(s_ready), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/haraka_feeder.md
# haraka_feeder

Host-side front end for the Haraka-512 permutation core. It collects a 512-bit message block as eight 64-bit words over a valid/ready stream and launches the core with a one-cycle start pulse. It captures the 512-bit permutation result, applies optional feed-forward, truncates to 256 bits, and returns four 64-bit digest words over a second valid/ready stream. It sits between the system bus adapter and the Haraka core and owns all sequencing of the core.

## Interface
Parameters:
- TIMEOUT, 16: maximum cycles to wait for `core_done` after `core_start`; range 2..255.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-low reset.
- s_data  in  64  message word; first accepted word is lane 0 = block bits [63:0].
- s_valid  in  1  producer has a word.
- s_ready  out  1  block accepts a word.
- m_data  out  64  digest word.
- m_valid  out  1  digest word valid.
- m_ready  in  1  consumer accepts digest word.
- core_in  out  512  block presented to core; held stable from `core_start` until `core_done`.
- core_start  out  1  one-cycle launch pulse.
- core_out  in  512  core result; sampled only in the `core_done` cycle.
- core_done  in  1  one-cycle completion pulse from core.
- busy  out  1  high in every state except LOAD.
- err  out  1  sticky timeout flag; cleared only by reset.

## Operation
- States: LOAD, RUN, WAIT, DRAIN.
- LOAD: `s_ready`=1. Each `s_valid&&s_ready` cycle writes lane `wcnt` (3-bit) of the block register and increments `wcnt`. After the 8th word (`wcnt`==7 with handshake), `wcnt` wraps to 0 and the state goes to RUN.
- RUN: lasts exactly one cycle. `core_start`=1 and `core_in`=block. The timeout counter loads 0. The state goes to WAIT. A `core_done` arriving in the RUN cycle is ignored.
- WAIT: the timeout counter increments each cycle.
  - On `core_done`: capture result r = `core_out` (feed-forward applied, see Configuration). The digest lanes are r lanes 1, 3, 4, 6 in that order. Lane k = bits [64k+63:64k]. The state goes to DRAIN with `dcnt`=0.
  - If the counter reaches TIMEOUT without `core_done`: set `err`, discard the block, and return to LOAD.
- DRAIN: `m_valid`=1 and `m_data`=digest[`dcnt`]. On `m_ready`, `dcnt` increments. After the 4th handshake the state returns to LOAD. `m_data` is stable while `m_valid && !m_ready`.
- `s_ready`=0 in RUN, WAIT and DRAIN, so input is back-pressured and there is no overlap between blocks.
- A `core_done` outside WAIT is ignored.
- Reset (at any time, including mid-block or mid-drain):
  - State goes to LOAD; `wcnt`, `dcnt` and the timeout counter go to 0; any partial block is lost.
  - Output reset values: `s_ready`=1, `m_valid`=0, `m_data`=0, `core_start`=0, `core_in`=0, `busy`=0, `err`=0.

## Timing
- 8th input handshake at cycle T -> `core_start` at T+1.
- `core_done` at cycle D -> first `m_valid` at D+1.
- With `m_ready` held high, the 4 digest words appear at D+1..D+4 and `s_ready` returns at D+5.
- Minimum block period: 8 + 1 + core latency + 4 cycles.
- Timeout: with no `core_done`, `err` rises at T+2+TIMEOUT and `s_ready` rises in the same cycle.
- All outputs are registered except `s_ready`, `m_valid` and `busy`, which decode the state register.

## Configuration
- HARAKA_FEEDFWD_EN defined: r = `core_out` XOR block (Haraka-512 feed-forward). The block register is held through WAIT.
- Not defined: r = `core_out`. The block register may be reused, and the digest is a plain truncation of the permutation.

## Test plan
- After reset, feed words 0x0..0x7 (lane k = k) and have the core model return `core_out` with lane k = 0x100+k after 10 cycles.
  - HARAKA_FEEDFWD_EN off: digest 0x101, 0x103, 0x104, 0x106.
  - HARAKA_FEEDFWD_EN on: digest 0x100, 0x100, 0x100, 0x100.
- Drain back-pressure: drop `m_ready` for 3 cycles on the 2nd digest word -> `m_data` is stable at the same value, no word is skipped or duplicated, and the total is exactly 4 words.
- Input gaps: toggle `s_valid` every other cycle -> `core_start` fires exactly one cycle after the 8th accepted word, and `core_in` matches the words in order.
- Timeout: run with TIMEOUT=16 and suppress `core_done` -> `err`=1 at T+18, the state returns to LOAD, a following block completes normally, and `err` stays 1.
- Reset mid-operation:
  - Assert reset after 5 words -> a new 8-word block produces a digest that uses only the new words.
  - Assert reset during DRAIN -> `m_valid` falls to 0 immediately and `s_ready`=1.
- Spurious `core_done` in the RUN cycle and in LOAD -> ignored, no capture, no state change.
